bcd_serial_add_ctrl: RTL

Sequencer that adds two multi-digit packed-BCD operands by time-sharing one single-digit BCD adder, least-significant digit first, one digit per clock.
- Operands are accepted with a start/busy/done handshake.
- Result and carry-out are registered and held until the next operation is accepted.
- Sits between a register/keypad front end and the display/result path of the BCD arithmetic unit.

---
 rtl/bcd_serial_add_ctrl_pkg.sv | 13 +
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_serial_add_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants and state type for the serial packed-BCD adder sequencer.
package bcd_serial_add_ctrl_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add of two digits plus carry, then decimal correction.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] w_bin;
    logic       w_corr;

    always_comb begin
        w_bin  = {1'b0, a} + {1'b0, b} + {4'd0, ci};
        // Result above 9 (or binary overflow) is pushed into the next decade by adding 6.
        w_corr = w_bin[4] | (w_bin[3] & w_bin[2]) | (w_bin[3] & w_bin[1]);
        s      = w_corr ? (w_bin[3:0] + 4'd6) : w_bin[3:0];
        co     = w_corr;
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that time-shares one digit adder, LSD first, one digit per clock.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DIGITS*BCD_DIGIT_W-1:0] a,
    input  logic [DIGITS*BCD_DIGIT_W-1:0] b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_DIGIT_W-1:0] sum,
    output logic                          cout,
    output logic                          err
);

    localparam int unsigned W     = DIGITS * BCD_DIGIT_W;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_dig_s;
    logic               w_dig_co;
    logic [W-1:0]       w_acc_nxt;
    logic [DIGITS-1:0]  w_bad;

    bcd_digit_add u_digit (
        .a  (r_a[BCD_DIGIT_W-1:0]),
        .b  (r_b[BCD_DIGIT_W-1:0]),
        .ci (r_carry),
        .s  (w_dig_s),
        .co (w_dig_co)
    );

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign w_bad[gi] = (a[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) |
                           (b[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX);
    end

    // New digit enters at the top so that after DIGITS steps digit 0 sits in [3:0].
    if (DIGITS == 1) begin : g_acc1
        assign w_acc_nxt = w_dig_s;
    end else begin : g_accn
        assign w_acc_nxt = {w_dig_s, r_acc[W-1:BCD_DIGIT_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
            r_err   <= |w_bad;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> BCD_DIGIT_W;
            r_b     <= r_b >> BCD_DIGIT_W;
            r_acc   <= w_acc_nxt;
            r_carry <= w_dig_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_dig_co;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
